// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: bit-serial unsigned magnitude comparator controller.
//   Compares two K-bit operands MSB first, one bit per cycle, stopping at the
//   first differing bit. Gives a start/busy/done handshake to the datapath.
// Latency: start to done is (bits examined)+1 cycles, i.e. 2 .. K+1 cycles.
// Backpressure: none; start is only sampled in IDLE and is never queued,
//   abort cancels a comparison in RUN without touching the held results.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : comparison request, sampled in IDLE only
//   abort           : synchronous cancel, effective in RUN only
//   a, b            : K-bit unsigned operands, captured on accepted start
//   busy            : high whenever the controller is not IDLE
//   done            : one-cycle pulse, result outputs were just updated
//   gt, eq, lt      : registered one-hot result of the last completed compare
//   cycles          : bit positions examined by the last completed compare

module serial_mag_cmp_ctrl #(
  parameter int K  = 8,
  parameter int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [K-1:0]  a,
  input  logic [K-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic          gt,
  output logic          eq,
  output logic          lt,
  output logic [CW-1:0] cycles
);

  // Bit index width; a 1-bit operand still needs a 1-bit index register.
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0] IDX_MSB = IW'(K - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [CW-1:0] K_CW    = CW'(K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q,  state_d;
  logic [K-1:0]  op_a_q,   op_a_d;
  logic [K-1:0]  op_b_q,   op_b_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          gt_q,     gt_d;
  logic          eq_q,     eq_d;
  logic          lt_q,     lt_d;
  logic [CW-1:0] cycles_q, cycles_d;

  // The single-bit compare slice: the bit pair currently under examination.
  logic bit_a;
  logic bit_b;

  always_comb begin
    bit_a = op_a_q[idx_q];
    bit_b = op_b_q[idx_q];
  end

  // Next-state and next-result logic. Results only change on RUN->DONE, so
  // every other path simply holds them.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    idx_d    = idx_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    cycles_d = cycles_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          idx_d   = IDX_MSB;
          state_d = RUN;
        end
      end

      RUN: begin
        // abort takes priority over a decision made in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (bit_a != bit_b) begin
          // Operands differ at idx: the larger one has the 1 here.
          gt_d     = bit_a;
          lt_d     = bit_b;
          eq_d     = 1'b0;
          cycles_d = K_CW - CW'(idx_q);
          state_d  = DONE;
        end else if (idx_q == '0) begin
          // Every bit matched down to the LSB.
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          eq_d     = 1'b1;
          cycles_d = K_CW;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign gt     = gt_q;
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Testbench for serial_mag_cmp_ctrl (K=8): directed vector table, randomized
// comparisons against an arithmetic reference, and hand-written sequences
// for back-to-back requests, abort and asynchronous reset.

module tb_serial_mag_cmp_ctrl;

  localparam int K  = 8;
  localparam int CW = $clog2(K + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [K-1:0]  a;
  logic [K-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [CW-1:0] cycles;

  int n_cmp = 0;
  int n_bad = 0;

  serial_mag_cmp_ctrl #(.K(K)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [K-1:0] va;
    logic [K-1:0] vb;
    int           egt;
    int           eeq;
    int           elt;
    int           ecyc;
    int           edone;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic for the relation; bits examined is the
  // distance from the MSB to the highest set bit of a^b, inclusive.
  function automatic void model(input logic [K-1:0] ma, input logic [K-1:0] mb,
                                output int mgt, output int meq, output int mlt,
                                output int mcyc);
    logic [K-1:0] x;
    int hi;
    mgt = (ma > mb) ? 1 : 0;
    meq = (ma == mb) ? 1 : 0;
    mlt = (ma < mb) ? 1 : 0;
    x = ma ^ mb;
    if (x == '0) begin
      mcyc = K;
    end else begin
      hi = 0;
      for (int i = 0; i < K; i++) if (x[i]) hi = i;
      mcyc = K - hi;
    end
  endfunction

  // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE.
  task automatic run_cmp(input logic [K-1:0] ta, input logic [K-1:0] tb_,
                         input int egt, input int eeq, input int elt,
                         input int ecyc, input int edone, input string nm);
    int got;
    int busy_ok;
    int n;
    a = ta;
    b = tb_;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = K'($urandom);      // scrambled after capture, must not matter
    b = K'($urandom);
    got = 0;
    busy_ok = 1;
    n = 1;
    while (got == 0 && n <= K + 3) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) begin
        got = n;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk({nm, " done_cycle"}, got, edone);
    chk({nm, " busy_while_active"}, busy_ok, 1);
    if (got != 0) begin
      chk({nm, " gt"}, int'(gt), egt);
      chk({nm, " eq"}, int'(eq), eeq);
      chk({nm, " lt"}, int'(lt), elt);
      chk({nm, " cycles"}, int'(cycles), ecyc);
    end
    @(negedge clk);
    chk({nm, " busy_after"}, int'(busy), 0);
    chk({nm, " done_after"}, int'(done), 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[4];

  initial begin
    int mgt, meq, mlt, mcyc;
    int seen;
    logic [K-1:0] ra, rb;

    vecs[0] = '{va: 8'hA5, vb: 8'h25, egt: 1, eeq: 0, elt: 0, ecyc: 1, edone: 2};
    vecs[1] = '{va: 8'h3C, vb: 8'h3D, egt: 0, eeq: 0, elt: 1, ecyc: 8, edone: 9};
    vecs[2] = '{va: 8'h5A, vb: 8'h5A, egt: 0, eeq: 1, elt: 0, ecyc: 8, edone: 9};
    vecs[3] = '{va: 8'h00, vb: 8'h80, egt: 0, eeq: 0, elt: 1, ecyc: 1, edone: 2};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset gt", int'(gt), 0);
    chk("reset eq", int'(eq), 0);
    chk("reset lt", int'(lt), 0);
    chk("reset cycles", int'(cycles), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_cmp(vecs[i].va, vecs[i].vb, vecs[i].egt, vecs[i].eeq, vecs[i].elt,
              vecs[i].ecyc, vecs[i].edone, $sformatf("vec%0d", i));
    end

    // Randomized against the reference model; bias toward equal / 1-bit-apart
    for (int i = 0; i < 30; i++) begin
      ra = K'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ K'(1 << $urandom_range(0, K - 1));
        default: rb = K'($urandom);
      endcase
      model(ra, rb, mgt, meq, mlt, mcyc);
      run_cmp(ra, rb, mgt, meq, mlt, mcyc, mcyc + 1, $sformatf("rnd%0d", i));
    end

    // Back-to-back: start held high, operands changed after capture
    a = 8'h80;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'h00;
    b = 8'hFF;
    @(negedge clk);
    chk("b2b c1 busy", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b c2 done", int'(done), 1);
    chk("b2b c2 gt", int'(gt), 1);
    chk("b2b c2 cycles", int'(cycles), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b c3 busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b c4 busy", int'(busy), 1);
    chk("b2b c4 done", int'(done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b c5 done", int'(done), 1);
    chk("b2b c5 lt", int'(lt), 1);
    chk("b2b c5 gt", int'(gt), 0);
    chk("b2b c5 cycles", int'(cycles), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Abort in the third RUN cycle
    run_cmp(8'h11, 8'h11, 0, 1, 0, 8, 9, "pre_abort");
    a = 8'h0F;
    b = 8'h0E;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort c3 busy", int'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort c4 busy", int'(busy), 0);
    chk("abort c4 done", int'(done), 0);
    chk("abort kept eq", int'(eq), 1);
    chk("abort kept cycles", int'(cycles), 8);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort no late done", seen, 0);
    @(posedge clk); #1;

    // Abort coinciding with the deciding RUN cycle
    a = 8'hA5;
    b = 8'h25;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_win done", int'(done), 0);
    chk("abort_win busy", int'(busy), 0);
    chk("abort_win gt", int'(gt), 0);
    chk("abort_win eq", int'(eq), 1);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN, then a fresh comparison
    a = 8'h03;
    b = 8'h03;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    chk("arst gt", int'(gt), 0);
    chk("arst eq", int'(eq), 0);
    chk("arst lt", int'(lt), 0);
    chk("arst cycles", int'(cycles), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmp(8'h01, 8'h02, 0, 0, 1, 7, 8, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
